fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
Round-robin write arbiter that shares one FIFO write port among NUM_REQ producers. It grants one producer at a time, forwards that producer's words to the FIFO's WEN/input_data, and honours the FIFO full flag in the same cycle. A grant is held for a burst of at most BURST_MAX accepted words, then released so the next producer can be served. The block sits directly in front of the FIFO's write side; the read side is unaffected.

Parameters:
NUM_REQ, 4, number of producers (>=2)
data_size, 8, word width; matches the FIFO data_size
BURST_MAX, 4, maximum words accepted per grant (>=1)

Ports:
clk  input  1  single clock; all state on posedge
reset  input  1  asynchronous, active-low reset (asserted at 0)
req  input  NUM_REQ  per-producer "word valid"; bit i belongs to producer i
req_data  input  NUM_REQ*data_size  producer i word at bits [i*data_size +: data_size]
ack  output  NUM_REQ  one-hot pulse: producer i's current word was written this cycle
grant  output  NUM_REQ  registered one-hot owner of the write port; 0 when idle
fifo_full  input  1  FIFO full flag
fifo_wen  output  1  FIFO write enable
fifo_data  output  data_size  FIFO write data
busy  output  1  1 while in GRANT state

Behaviour:
- Reset (reset=0, async): state=IDLE, grant=0, burst_cnt=0, last_idx=NUM_REQ-1 (producer 0 has first priority). ack=0, fifo_wen=0, busy=0. fifo_data is don't-care while fifo_wen=0; drive 0 in IDLE.
- Reset mid-burst: the in-flight word is not written; no ack is issued; producers keep req asserted and re-arbitrate after release.
- State IDLE: if req!=0, choose the first i with req[i]=1, searching last_idx+1, last_idx+2, ... modulo NUM_REQ. Next cycle: state=GRANT, grant=onehot(i), grant_idx=i, burst_cnt=0. If req=0, stay in IDLE. No write occurs in IDLE; each grant costs exactly one arbitration bubble cycle.
- State GRANT (combinational outputs from registered grant_idx):
  - accept = req[grant_idx] & ~fifo_full
  - fifo_wen = accept
  - fifo_data = req_data slice grant_idx
  - ack = accept ? grant : 0
- On accept: burst_cnt increments. burst_cnt width is clog2(BURST_MAX+1); it never wraps.
- Release (next state IDLE, last_idx=grant_idx, grant=0, burst_cnt=0) occurs when either condition holds:
  - req[grant_idx]=0 (owner withdrew); or
  - accept=1 and burst_cnt==BURST_MAX-1 (this is the last word of the burst).
- fifo_full=1 with req held: no write, no ack. Grant and burst_cnt are held with no timeout; the stall lasts until full clears.
- Other producers' req are ignored while in GRANT. A producer must hold req and req_data stable until it sees ack.
- The full flag is sampled in the same cycle as WEN, so a word is never presented to a full FIFO. Back-to-back writes run at 1 word/clk within a burst.
- Throughput per grant: 1 bubble cycle + up to BURST_MAX words.

Test Plan:
- Reset: hold reset=0 with req=4'b1111 -> grant=0, fifo_wen=0, ack=0, busy=0. Release reset -> IDLE cycle, then grant=4'b0001.
- Burst limit: req=4'b0001 held, BURST_MAX=4, FIFO not full -> fifo_wen=1 for exactly 4 consecutive cycles, ack[0] pulses 4 times, then 1 IDLE cycle, then grant=4'b0001 again.
- Round-robin fairness: req=4'b1011 continuously -> grant order 0001, 0010, 1000, 0001, ... Each grant gives 4 words; producer 2 is never granted.
- Early withdraw: producer 1 granted, drops req after 2 acks -> release next cycle, burst_cnt reset, last_idx=1, next grant goes to the lowest requester above 1 (cyclically).
- Full stall: mid-burst after 1 word, fifo_full=1 for 5 cycles -> fifo_wen=0, ack=0, grant unchanged. After full clears, the remaining 3 words are written and then the grant is released.
- Async reset mid-burst: assert reset between clock edges during GRANT -> grant, ack, fifo_wen drop to 0 immediately. After reset release, producer 0 is granted first.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin arbiter sharing one FIFO write port among producers
// Grants one producer at a time for a burst of up to BURST_MAX words, honouring fifo_full in the same cycle.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int data_size = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*data_size-1:0] req_data,
  output logic [NUM_REQ-1:0]           ack,
  output logic [NUM_REQ-1:0]           grant,
  input  logic                         fifo_full,
  output logic                         fifo_wen,
  output logic [data_size-1:0]         fifo_data,
  output logic                         busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BURST_MAX - 1);
  localparam logic [IDX_W-1:0]   LAST_REQ  = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [0:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [IDX_W-1:0]   last_idx_q, last_idx_d;

  logic [data_size-1:0] word [NUM_REQ];
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     cand;
  logic                 owner_req;
  logic                 accept;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      word[i] = req_data[i*data_size +: data_size];
    end
  end

  // Search starts just after the last owner so every requester is reached within NUM_REQ grants.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_idx_q) + k) % NUM_REQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign owner_req = req[grant_idx_q];
  assign accept    = (state_q == ST_GRANT) && owner_req && !fifo_full;

  assign fifo_wen  = accept;
  assign ack       = accept ? grant_q : '0;
  assign grant     = grant_q;
  assign busy      = (state_q == ST_GRANT);
  assign fifo_data = busy ? word[grant_idx_q] : '0;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    burst_cnt_d = burst_cnt_q;
    last_idx_d  = last_idx_q;
    if (state_q == ST_IDLE) begin
      if (pick_valid) begin
        state_d     = ST_GRANT;
        grant_d     = ONE_HOT0 << pick_idx;
        grant_idx_d = pick_idx;
        burst_cnt_d = '0;
      end
    end else begin
      // A full FIFO only stalls; the grant is given up on withdraw or on the final word of the burst.
      if (!owner_req || (accept && burst_cnt_q == LAST_BEAT)) begin
        state_d     = ST_IDLE;
        grant_d     = '0;
        burst_cnt_d = '0;
        last_idx_d  = grant_idx_q;
      end else if (accept) begin
        burst_cnt_d = burst_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      burst_cnt_q <= '0;
      last_idx_q  <= LAST_REQ;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      burst_cnt_q <= burst_cnt_d;
      last_idx_q  <= last_idx_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - scoreboard bench for fifo_write_arbiter
// Producers are modelled in the bench; expected writes are queued up front and popped by a negedge monitor.
module tb_fifo_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N*W-1:0] req_data;
  logic [N-1:0] ack;
  logic [N-1:0] grant;
  logic         fifo_full;
  logic         fifo_wen;
  logic [W-1:0] fifo_data;
  logic         busy;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  int           remaining [N];
  logic [W-1:0] word [N];
  logic [N-1:0] s_grant;
  logic [N-1:0] s_ack;
  logic         s_wen;
  logic         s_busy;
  logic [N-1:0] prev_grant = '0;
  logic [N-1:0] grant_log[$];

  int exp_b [11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  int exp_f [6]  = '{2, 8, 1, 2, 8, 1};

  fifo_write_arbiter #(.NUM_REQ(N), .data_size(W), .BURST_MAX(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .grant     (grant),
    .fifo_full (fifo_full),
    .fifo_wen  (fifo_wen),
    .fifo_data (fifo_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (fifo_wen === 1'b1) begin
      chk("wen_while_full", 32'(fifo_full), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got data %0h grant %0h expected no write", fifo_data, grant);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_data", 32'(fifo_data), 32'(mon_e.data));
        chk("wr_ack", 32'(ack), 32'(1) << mon_e.idx);
        chk("wr_grant", 32'(grant), 32'(1) << mon_e.idx);
      end
    end else begin
      chk("ack_without_wen", 32'(ack), 32'd0);
    end
  end

  task automatic push(input int idx, input logic [W-1:0] d);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req[i]             = (remaining[i] > 0);
      req_data[i*W +: W] = word[i];
    end
  endtask

  task automatic step();
    @(negedge clk);
    s_grant = grant;
    s_wen   = fifo_wen;
    s_ack   = ack;
    s_busy  = busy;
    if (s_grant != '0 && prev_grant == '0) grant_log.push_back(s_grant);
    prev_grant = s_grant;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (s_ack[i]) begin
        remaining[i] = remaining[i] - 1;
        word[i]      = word[i] + 8'd1;
      end
    end
    apply();
  endtask

  function automatic bit all_done();
    bit d = 1'b1;
    for (int i = 0; i < N; i++) if (remaining[i] != 0) d = 1'b0;
    return d;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && all_done() && s_busy == 1'b0) && n < 300) begin
      step();
      n++;
    end
    chk({name, "_drained"}, 32'(n < 300), 32'd1);
    step();
  endtask

  initial begin
    reset     = 1'b0;
    fifo_full = 1'b0;
    req       = '0;
    req_data  = '0;
    s_busy    = 1'b0;

    // Reset held with all producers requesting.
    remaining = '{1, 1, 1, 1};
    word      = '{8'h0A, 8'h1A, 8'h2A, 8'h3A};
    apply();
    step();
    step();
    chk("rst_grant", 32'(s_grant), 32'd0);
    chk("rst_wen", 32'(s_wen), 32'd0);
    chk("rst_ack", 32'(s_ack), 32'd0);
    chk("rst_busy", 32'(s_busy), 32'd0);
    push(0, 8'h0A); push(1, 8'h1A); push(2, 8'h2A); push(3, 8'h3A);
    reset = 1'b1;
    step();
    chk("post_rst_idle_grant", 32'(s_grant), 32'd0);
    chk("post_rst_idle_busy", 32'(s_busy), 32'd0);
    step();
    chk("post_rst_first_grant", 32'(s_grant), 32'h1);
    chk("post_rst_first_wen", 32'(s_wen), 32'd1);
    drain("s1");

    // Burst limit: single producer with 8 words -> two bursts of 4 split by a bubble.
    remaining[0] = 8;
    word[0]      = 8'h10;
    for (int k = 0; k < 8; k++) push(0, 8'(8'h10 + k));
    apply();
    for (int c = 0; c < 11; c++) begin
      step();
      chk($sformatf("burst_wen_c%0d", c), 32'(s_wen), 32'(exp_b[c]));
      chk($sformatf("burst_grant_c%0d", c), 32'(s_grant), 32'(exp_b[c]));
    end
    drain("s2");

    // Fairness: producers 0, 1, 3 with 8 words each; last owner was 0.
    remaining = '{8, 8, 0, 8};
    word      = '{8'h20, 8'h30, 8'h00, 8'h50};
    for (int k = 0; k < 4; k++) push(1, 8'(8'h30 + k));
    for (int k = 0; k < 4; k++) push(3, 8'(8'h50 + k));
    for (int k = 0; k < 4; k++) push(0, 8'(8'h20 + k));
    for (int k = 0; k < 4; k++) push(1, 8'(8'h34 + k));
    for (int k = 0; k < 4; k++) push(3, 8'(8'h54 + k));
    for (int k = 0; k < 4; k++) push(0, 8'(8'h24 + k));
    grant_log.delete();
    apply();
    drain("s3");
    chk("fair_grant_count", 32'(grant_log.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < grant_log.size()) chk($sformatf("fair_grant_%0d", k), 32'(grant_log[k]), 32'(exp_f[k]));
    end

    // Early withdraw: producer 1 leaves after 2 words, next goes to 3 then 0.
    remaining = '{2, 2, 0, 3};
    word      = '{8'h70, 8'h40, 8'h00, 8'h60};
    push(1, 8'h40); push(1, 8'h41);
    push(3, 8'h60); push(3, 8'h61); push(3, 8'h62);
    push(0, 8'h70); push(0, 8'h71);
    apply();
    step();
    step();
    chk("wd_first_grant", 32'(s_grant), 32'h2);
    step();
    step();
    chk("wd_release_grant_held", 32'(s_grant), 32'h2);
    chk("wd_release_wen", 32'(s_wen), 32'd0);
    step();
    chk("wd_bubble_grant", 32'(s_grant), 32'd0);
    step();
    chk("wd_next_grant", 32'(s_grant), 32'h8);
    drain("s4");

    // Full stall after one word for five cycles.
    remaining[0] = 4;
    word[0]      = 8'h80;
    for (int k = 0; k < 4; k++) push(0, 8'(8'h80 + k));
    apply();
    step();
    step();
    chk("full_first_wen", 32'(s_wen), 32'd1);
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("full_stall_wen_%0d", c), 32'(s_wen), 32'd0);
      chk($sformatf("full_stall_grant_%0d", c), 32'(s_grant), 32'h1);
    end
    fifo_full = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("full_resume_wen_%0d", c), 32'(s_wen), 32'd1);
    end
    step();
    chk("full_release_grant", 32'(s_grant), 32'd0);
    drain("s5");

    // Asynchronous reset in the middle of producer 2's burst.
    remaining = '{2, 0, 4, 0};
    word      = '{8'hA0, 8'h00, 8'h90, 8'h00};
    push(2, 8'h90); push(2, 8'h91);
    push(0, 8'hA0); push(0, 8'hA1);
    push(2, 8'h92); push(2, 8'h93);
    apply();
    step();
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_wen", 32'(fifo_wen), 32'd0);
    chk("arst_ack", 32'(ack), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("arst_idle_grant", 32'(s_grant), 32'd0);
    step();
    chk("arst_first_grant", 32'(s_grant), 32'h1);
    drain("s6");

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
